// File: rtl/bcd_updown_counter.sv
// Parameterised multi-digit BCD up/down counter with load, clamp-on-load and wrap flags.
// Define BCDCNT_SATURATE_EN to hold at the boundaries instead of wrapping (carry/borrow tied 0).
module bcd_updown_counter #(
  parameter int                    DIGITS      = 2,
  parameter logic [4*DIGITS-1:0]   LIMIT       = (4*DIGITS)'(8'h59),
  parameter logic [4*DIGITS-1:0]   RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry,
  output logic                  borrow,
  output logic                  at_limit,
  output logic                  at_zero
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] next_value;
  logic [W-1:0] load_clean;

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple the +1 through digits: a digit moves only while every lower digit was 9.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign at_limit = (value == LIMIT);
  assign at_zero  = (value == '0);

  // With every digit valid, BCD numeric order equals plain unsigned order of the vector.
  always_comb begin
    if (!is_bcd(load_value))    load_clean = '0;
    else if (load_value > LIMIT) load_clean = LIMIT;
    else                         load_clean = load_value;
  end

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_value = value;
    if (load) begin
      next_value = load_clean;
    end else if (en) begin
      if (up_dn) begin
`ifdef BCDCNT_SATURATE_EN
        if (!at_limit) next_value = bcd_inc(value);
`else
        next_value = at_limit ? '0 : bcd_inc(value);
`endif
      end else begin
`ifdef BCDCNT_SATURATE_EN
        if (!at_zero) next_value = bcd_dec(value);
`else
        next_value = at_zero ? LIMIT : bcd_dec(value);
`endif
      end
    end
  end

`ifdef BCDCNT_SATURATE_EN
  assign carry  = 1'b0;
  assign borrow = 1'b0;
`else
  // Gated by rst so neither flag can fire while the counter is held in reset.
  assign carry  = rst & en &  up_dn & at_limit & ~load;
  assign borrow = rst & en & ~up_dn & at_zero  & ~load;
`endif

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value <= RESET_VALUE;
    else      value <= next_value;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits; legal range 1..8.
REQ-002 Parameter LIMIT, default 8'h59, upper count limit in BCD; width 4*DIGITS; every digit SHALL be 0..9.
REQ-003 Parameter RESET_VALUE, default 0, BCD value loaded on reset; SHALL be <= LIMIT.
REQ-004 clk  input  1  global clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; 1 = step one count this cycle.
REQ-007 up_dn  input  1  direction; 1 = up, 0 = down.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_value  input  4*DIGITS  BCD value to load.
REQ-010 value  output  4*DIGITS  registered counter value, digit 0 in bits [3:0].
REQ-011 carry  output  1  combinational; up-step wraps LIMIT -> 0 this cycle.
REQ-012 borrow  output  1  combinational; down-step wraps 0 -> LIMIT this cycle.
REQ-013 at_limit  output  1  combinational; value == LIMIT.
REQ-014 at_zero  output  1  combinational; value == 0.

Function
REQ-015 Priority per cycle SHALL be: load, then en; en=0 and load=0 holds value.
REQ-016 load SHALL take effect regardless of en; carry and borrow SHALL be 0 in a load cycle.
REQ-017 Load: any load_value digit > 9 SHALL load 0; else load_value > LIMIT (BCD numeric compare) SHALL load LIMIT; else load_value.
REQ-018 Up-step: digit i SHALL increment when en=1, up_dn=1 and all digits below i equal 9; digit 9 SHALL wrap to 0.
REQ-019 Down-step: digit i SHALL decrement when en=1, up_dn=0 and all digits below i equal 0; digit 0 SHALL wrap to 9.
REQ-020 Up-step at value == LIMIT SHALL produce value 0 next cycle and assert carry that cycle.
REQ-021 Down-step at value == 0 SHALL produce value LIMIT next cycle and assert borrow that cycle.
REQ-022 carry SHALL equal en & up_dn & at_limit & ~load; borrow SHALL equal en & ~up_dn & at_zero & ~load.
REQ-023 Latency: value SHALL reflect a step or load one clk edge after the request; flags are zero-latency combinational.
REQ-024 value SHALL never be non-BCD or exceed LIMIT in any reachable state.
REQ-025 up_dn change between cycles SHALL take effect immediately; no turnaround cycle.
REQ-026 carry output SHALL be usable directly as en of a cascaded next stage on the same clk.

Reset
REQ-027 rst=0 SHALL asynchronously force value to RESET_VALUE regardless of clk.
REQ-028 During reset carry=0, borrow=0; at_limit, at_zero SHALL track RESET_VALUE.
REQ-029 Reset asserted mid-step or mid-load SHALL override; first step after rst release uses RESET_VALUE as start.

Configuration
REQ-030 Macro BCDCNT_SATURATE_EN SHALL select boundary behaviour.
REQ-031 Without BCDCNT_SATURATE_EN: wrap per REQ-020/021.
REQ-032 With BCDCNT_SATURATE_EN: up-step at LIMIT and down-step at 0 SHALL hold value; carry and borrow SHALL be tied 0; all other requirements unchanged.

Verification (DIGITS=2, LIMIT=8'h59, RESET_VALUE=0)
REQ-033 rst=0 mid-count at value 8'h37 -> value 8'h00 immediately, before next clk edge; carry=borrow=0.
REQ-034 en=1 up_dn=1 from 8'h58 for 3 cycles -> values 8'h59, 8'h00, 8'h01; carry high only in the 8'h59 cycle.
REQ-035 en=1 up_dn=0 from 8'h10 for 2 cycles -> 8'h09, 8'h08; from 8'h00 one step -> 8'h59 with borrow=1.
REQ-036 load=1 en=1 load_value 8'h72 -> 8'h59; load_value 8'h3A -> 8'h00; load_value 8'h42 -> 8'h42; carry=0 in all load cycles.
REQ-037 BCDCNT_SATURATE_EN defined: up-step at 8'h59 -> stays 8'h59, carry=0; down-step at 8'h00 -> stays 8'h00, borrow=0.
REQ-038 Two instances cascaded (stage B en = stage A carry): 60 up-steps on A -> B increments exactly once.
